// File: rtl/input_conditioner.sv
// rtl/input_conditioner.sv - synchroniser, debouncer and edge/toggle detector for one raw input
// Every output is a flop; din only ever reaches the first synchroniser stage.

module input_conditioner #(
   parameter int unsigned SYNC_STAGES     = 2,
   parameter int unsigned DEBOUNCE_CYCLES = 16
) (
   input  logic clk,
   input  logic reset,
   input  logic din,
   output logic dout,
   output logic rise,
   output logic fall,
   output logic toggle
);

   localparam int unsigned CW = (DEBOUNCE_CYCLES <= 2) ? 1 : $clog2(DEBOUNCE_CYCLES);
   localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

   logic [SYNC_STAGES-1:0] sync_q, sync_d;
   logic [CW-1:0]          cnt_q, cnt_d;
   logic                   dout_q, dout_d;
   logic                   rise_q, rise_d;
   logic                   fall_q, fall_d;
   logic                   toggle_q, toggle_d;
   logic                   s;

   assign s = sync_q[SYNC_STAGES-1];

   always_comb begin
      sync_d   = {sync_q[SYNC_STAGES-2:0], din};
      cnt_d    = '0;
      dout_d   = dout_q;
      rise_d   = 1'b0;
      fall_d   = 1'b0;
      toggle_d = toggle_q;
      // Any matching sample clears the count, so only an unbroken run is accepted.
      if (s != dout_q) begin
         if (cnt_q == CNT_LAST) begin
            dout_d   = s;
            rise_d   = s;
            fall_d   = ~s;
            toggle_d = toggle_q ^ s;
         end else begin
            cnt_d = cnt_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         sync_q   <= '0;
         cnt_q    <= '0;
         dout_q   <= 1'b0;
         rise_q   <= 1'b0;
         fall_q   <= 1'b0;
         toggle_q <= 1'b0;
      end else begin
         sync_q   <= sync_d;
         cnt_q    <= cnt_d;
         dout_q   <= dout_d;
         rise_q   <= rise_d;
         fall_q   <= fall_d;
         toggle_q <= toggle_d;
      end
   end

   assign dout   = dout_q;
   assign rise   = rise_q;
   assign fall   = fall_q;
   assign toggle = toggle_q;

endmodule

// File: tb/tb_input_conditioner.sv
// tb/tb_input_conditioner.sv - directed self-checking bench for input_conditioner
// Expected output vectors are {dout, rise, fall, toggle}, hand-derived per edge.

module tb_input_conditioner;

   logic clk = 1'b0;
   logic reset;
   logic din;
   logic dout, rise, fall, toggle;

   int compared   = 0;
   int mismatched = 0;

   input_conditioner #(
      .SYNC_STAGES     (2),
      .DEBOUNCE_CYCLES (4)
   ) dut (
      .clk    (clk),
      .reset  (reset),
      .din    (din),
      .dout   (dout),
      .rise   (rise),
      .fall   (fall),
      .toggle (toggle)
   );

   always #5 clk = ~clk;

   // Advance n rising edges, sampling 1 time unit after each edge.
   task automatic run(input int n, input logic [3:0] exp, input string tag);
      logic [3:0] obs;
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
         obs = {dout, rise, fall, toggle};
         compared++;
         assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s step %0d: observed %b expected %b (dout,rise,fall,toggle)",
                   tag, i, obs, exp);
         end
      end
   endtask

   initial begin
      logic tog;

      reset = 1'b1;
      din   = 1'b0;
      run(3, 4'b0000, "reset_state");
      reset = 1'b0;
      run(20, 4'b0000, "idle_low");

      // Clean rise: accepted at edge 6, pulse for one cycle.
      din = 1'b1;
      run(5, 4'b0000, "rise_wait");
      run(1, 4'b1101, "rise_edge6");
      run(1, 4'b1001, "rise_edge7");
      run(5, 4'b1001, "rise_hold");

      // Clean fall: toggle keeps its value.
      din = 1'b0;
      run(5, 4'b1001, "fall_wait");
      run(1, 4'b0011, "fall_edge6");
      run(6, 4'b0001, "fall_hold");

      // Three cycles high on s: rejected.
      din = 1'b1;
      run(3, 4'b0001, "glitch3_high");
      din = 1'b0;
      run(10, 4'b0001, "glitch3_reject");

      // Exactly four cycles high on s: accepted, then four low also accepted.
      din = 1'b1;
      run(4, 4'b0001, "glitch4_high");
      din = 1'b0;
      run(1, 4'b0001, "glitch4_wait");
      run(1, 4'b1100, "glitch4_rise");
      run(3, 4'b1000, "glitch4_hold");
      run(1, 4'b0010, "glitch4_fall");
      run(3, 4'b0000, "glitch4_after");

      // Bounce for 10 cycles then settle high: one rise, 6 edges after last change.
      reset = 1'b1;
      run(2, 4'b0000, "bounce_reset");
      reset = 1'b0;
      for (int i = 0; i < 10; i++) begin
         din = ~i[0];
         run(1, 4'b0000, "bounce_active");
      end
      din = 1'b1;
      run(5, 4'b0000, "bounce_settle");
      run(1, 4'b1101, "bounce_rise");
      run(4, 4'b1001, "bounce_hold");

      // Three clean press/release cycles: toggle goes 1, 0, 1.
      reset = 1'b1;
      run(2, 4'b0000, "press_reset");
      reset = 1'b0;
      tog = 1'b0;
      for (int i = 0; i < 3; i++) begin
         din = 1'b1;
         run(5, {3'b000, tog}, "press_wait");
         tog = ~tog;
         run(1, {3'b110, tog}, "press_rise");
         run(6, {3'b100, tog}, "press_hold");
         din = 1'b0;
         run(5, {3'b100, tog}, "release_wait");
         run(1, {3'b001, tog}, "release_fall");
         run(6, {3'b000, tog}, "release_hold");
      end

      // Reset at edge 4 of a valid count, din held high through release.
      din = 1'b1;
      run(3, 4'b0001, "midreset_count");
      reset = 1'b1;
      run(2, 4'b0000, "midreset_active");
      reset = 1'b0;
      run(5, 4'b0000, "midreset_wait");
      run(1, 4'b1101, "midreset_rise");
      run(3, 4'b1001, "midreset_hold");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
